// File: rtl/alu_mul_sequencer_pkg.sv
// Shared encodings for the EX-stage multiply sequencer: opcode, ALU control codes
// and the sequencer state type.
package alu_mul_sequencer_pkg;

   localparam logic [10:0] OPC_MUL = 11'h4D8;

   localparam logic [3:0] NOP     = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0010;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_RUN  = 2'd1,
      SEQ_DONE = 2'd2
   } seq_state_t;

   function automatic logic is_mul(input logic [10:0] opcode);
      return opcode == OPC_MUL;
   endfunction

   function automatic logic [3:0] alu_ctrl_for(input logic own);
      return own ? ALU_ADD : NOP;
   endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bus between the EX stage and the multiply sequencer, including the borrowed ALU path.
interface alu_mul_sequencer_if #(parameter int WIDTH = 64);
   import alu_mul_sequencer_pkg::*;

   // Handshake: start is a level request that is accepted only on a clock edge where the
   // sequencer is IDLE and flush is low; starts at any other time are dropped, not queued.
   // done pulses for exactly one cycle when result is valid, and result then holds until
   // the next accepted start. stall is combinational so the pipeline freezes in the
   // same cycle that start is accepted.
   logic             start;
   logic             flush;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_own;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_in_a;
   logic [WIDTH-1:0] alu_in_b;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result;
   seq_state_t       dbg_state;

   modport slave (
      input  start, flush, op_a, op_b, alu_result,
      output alu_own, alu_ctrl, alu_in_a, alu_in_b, busy, stall, done, result, dbg_state
   );

   modport master (
      output start, flush, op_a, op_b, alu_result,
      input  alu_own, alu_ctrl, alu_in_a, alu_in_b, busy, stall, done, result, dbg_state
   );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Radix-2 shift-add multiplier that borrows the shared EX-stage ALU for its additions
// and stalls the front of the pipeline until the low half of the product is ready.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter bit EARLY_EXIT = 1'b1
) (
   input logic               clk,
   input logic               reset,
   alu_mul_sequencer_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   seq_state_t       state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] result;
   logic [CW-1:0]    count;

   logic is_idle;
   logic is_run;
   logic last_step;

   assign is_idle = (state == SEQ_IDLE);
   assign is_run  = (state == SEQ_RUN);

   // With early exit, stop once no set multiplier bits remain after this step.
   assign last_step = (count == LAST_STEP) ||
                      (EARLY_EXIT && ((mplier >> 1) == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= SEQ_IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         result <= '0;
         count  <= '0;
      end else begin
         case (state)
            SEQ_IDLE: begin
               if (bus.start && !bus.flush) begin
                  acc    <= '0;
                  mcand  <= bus.op_a;
                  mplier <= bus.op_b;
                  count  <= '0;
                  if (EARLY_EXIT && (bus.op_b == '0)) begin
                     result <= '0;
                     state  <= SEQ_DONE;
                  end else begin
                     state  <= SEQ_RUN;
                  end
               end
            end
            SEQ_RUN: begin
               if (bus.flush) begin
                  state <= SEQ_IDLE;
               end else begin
                  acc    <= bus.alu_result;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  count  <= count + CW'(1);
                  if (last_step) begin
                     result <= bus.alu_result;
                     state  <= SEQ_DONE;
                  end
               end
            end
            SEQ_DONE: state <= SEQ_IDLE;
            default:  state <= SEQ_IDLE;
         endcase
      end
   end

   // ALU-facing outputs are forced to NOP/0 whenever the pipeline owns the ALU.
   assign bus.alu_own   = is_run;
   assign bus.alu_ctrl  = alu_ctrl_for(is_run);
   assign bus.alu_in_a  = is_run ? acc : '0;
   assign bus.alu_in_b  = (is_run && mplier[0]) ? mcand : '0;
   assign bus.busy      = !is_idle;
   assign bus.done      = (state == SEQ_DONE);
   assign bus.stall     = ((bus.start && is_idle) || is_run) && !bus.flush;
   assign bus.result    = result;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: one instance with early exit, one with fixed latency.
module tb_alu_mul_sequencer;
   import alu_mul_sequencer_pkg::*;

   typedef logic [63:0] w_t;

   logic clk;
   logic reset;
   int   cyc;

   alu_mul_sequencer_if #(.WIDTH(64)) b0 ();
   alu_mul_sequencer_if #(.WIDTH(64)) b1 ();

   alu_mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b1)) dut_ee (
      .clk   (clk),
      .reset (reset),
      .bus   (b0.slave)
   );

   alu_mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b0)) dut_full (
      .clk   (clk),
      .reset (reset),
      .bus   (b1.slave)
   );

   // Model of the shared ALU: adds when told to, otherwise outputs zero.
   assign b0.alu_result = (b0.alu_ctrl == ALU_ADD) ? (b0.alu_in_a + b0.alu_in_b) : 64'd0;
   assign b1.alu_result = (b1.alu_ctrl == ALU_ADD) ? (b1.alu_in_a + b1.alu_in_b) : 64'd0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   w_t exp_q0[$];
   w_t exp_q1[$];
   int cyc_q0[$];
   int cyc_q1[$];
   int checks = 0;
   int passed = 0;
   w_t last_res0 = 64'd0;
   w_t last_res1 = 64'd0;

   task automatic check(input string name, input w_t act, input w_t exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
   endtask

   w_t m_exp0, m_exp1;
   int m_cyc0, m_cyc1;

   always @(negedge clk) begin
      if (!reset && b0.done) begin
         if (exp_q0.size() == 0) begin
            check_bit("unexpected_done_ee", b0.done, 1'b0);
         end else begin
            m_exp0 = exp_q0.pop_front();
            m_cyc0 = cyc_q0.pop_front();
            check("result_ee", b0.result, m_exp0);
            check("done_cycle_ee", w_t'(cyc), w_t'(m_cyc0));
         end
      end
      if (!reset && b1.done) begin
         if (exp_q1.size() == 0) begin
            check_bit("unexpected_done_full", b1.done, 1'b0);
         end else begin
            m_exp1 = exp_q1.pop_front();
            m_cyc1 = cyc_q1.pop_front();
            check("result_full", b1.result, m_exp1);
            check("done_cycle_full", w_t'(cyc), w_t'(m_cyc1));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_in(input bit sel, input logic st, input logic fl, input w_t a, input w_t b);
      if (sel) begin
         b1.start = st; b1.flush = fl; b1.op_a = a; b1.op_b = b;
      end else begin
         b0.start = st; b0.flush = fl; b0.op_a = a; b0.op_b = b;
      end
   endtask

   // {stall, busy, alu_own, done}
   function automatic logic [3:0] obs(input bit sel);
      return sel ? {b1.stall, b1.busy, b1.alu_own, b1.done}
                 : {b0.stall, b0.busy, b0.alu_own, b0.done};
   endfunction

   task automatic run_op(input bit sel, input w_t a, input w_t b, input w_t exp_res,
                         input int lat, input bit poke);
      int c;
      logic [3:0] f;
      @(posedge clk); #1;
      set_in(sel, 1'b1, 1'b0, a, b);
      c = cyc;
      if (sel) begin exp_q1.push_back(exp_res); cyc_q1.push_back(c + lat); end
      else     begin exp_q0.push_back(exp_res); cyc_q0.push_back(c + lat); end
      @(negedge clk);
      f = obs(sel);
      check_bit("stall_on_start", f[3], 1'b1);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         if (poke && k == 2) set_in(sel, 1'b1, 1'b0, 64'd9, 64'd9);
         else                set_in(sel, 1'b0, 1'b0, a, b);
         @(negedge clk);
         f = obs(sel);
         check_bit("stall", f[3], k < lat);
         check_bit("busy", f[2], 1'b1);
         check_bit("alu_own", f[1], k < lat);
         if (k < lat) begin
            check("alu_ctrl_add", w_t'(sel ? b1.alu_ctrl : b0.alu_ctrl), w_t'(ALU_ADD));
         end else begin
            check("alu_ctrl_nop", w_t'(sel ? b1.alu_ctrl : b0.alu_ctrl), w_t'(NOP));
            check("alu_in_a_idle", sel ? b1.alu_in_a : b0.alu_in_a, 64'd0);
            check("alu_in_b_idle", sel ? b1.alu_in_b : b0.alu_in_b, 64'd0);
         end
      end
      if (sel) last_res1 = exp_res;
      else     last_res0 = exp_res;
   endtask

   task automatic run_flush(input bit sel, input w_t a, input w_t b, input int fk);
      logic [3:0] f;
      @(posedge clk); #1;
      set_in(sel, 1'b1, 1'b0, a, b);
      for (int k = 1; k <= fk; k++) begin
         @(posedge clk); #1;
         set_in(sel, 1'b0, (k == fk), a, b);
         @(negedge clk);
         f = obs(sel);
         check_bit("flush_busy_run", f[2], 1'b1);
         check_bit("flush_own_run", f[1], 1'b1);
      end
      @(posedge clk); #1;
      set_in(sel, 1'b0, 1'b0, a, b);
      @(negedge clk);
      f = obs(sel);
      check_bit("flush_busy", f[2], 1'b0);
      check_bit("flush_stall", f[3], 1'b0);
      check_bit("flush_own", f[1], 1'b0);
      check("flush_result_held", sel ? b1.result : b0.result, sel ? last_res1 : last_res0);
      repeat (3) @(posedge clk);
   endtask

   task automatic start_with_flush(input bit sel);
      logic [3:0] f;
      @(posedge clk); #1;
      set_in(sel, 1'b1, 1'b1, 64'd5, 64'd5);
      @(negedge clk);
      f = obs(sel);
      check_bit("start_flush_stall", f[3], 1'b0);
      @(posedge clk); #1;
      set_in(sel, 1'b0, 1'b0, 64'd0, 64'd0);
      @(negedge clk);
      f = obs(sel);
      check_bit("start_flush_busy", f[2], 1'b0);
      check("start_flush_result", sel ? b1.result : b0.result, sel ? last_res1 : last_res0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [3:0] f;
      int waited;
      reset = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      set_in(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      f = obs(1'b0);
      check("reset_flags_ee", w_t'(f), 64'd0);
      f = obs(1'b1);
      check("reset_flags_full", w_t'(f), 64'd0);
      check("reset_result_ee", b0.result, 64'd0);
      check("reset_ctrl_ee", w_t'(b0.alu_ctrl), w_t'(NOP));
      check("reset_state_ee", w_t'(b0.dbg_state), w_t'(SEQ_IDLE));
      reset = 1'b0;

      run_op(1'b0, 64'd3, 64'd5, 64'd15, 4, 1'b0);
      run_op(1'b0, 64'd123, 64'd0, 64'd0, 1, 1'b0);
      run_op(1'b0, 64'd12345, 64'd1, 64'd12345, 2, 1'b0);
      run_op(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0001,
             64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0);
      run_op(1'b0, 64'd2, 64'h8000_0000_0000_0000, 64'd0, 65, 1'b0);
      run_op(1'b0, 64'd6, 64'd7, 64'd42, 4, 1'b1);
      run_flush(1'b0, 64'd7, 64'h8000_0000_0000_0000, 10);
      start_with_flush(1'b0);

      run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65, 1'b0);
      run_op(1'b1, 64'd9, 64'd0, 64'd0, 65, 1'b0);
      run_op(1'b1, 64'd3, 64'd5, 64'd15, 65, 1'b0);
      run_flush(1'b1, 64'd5, 64'd5, 3);

      // asynchronous reset in the middle of a long early-exit multiply
      @(posedge clk); #1;
      set_in(1'b0, 1'b1, 1'b0, 64'd3, 64'h8000_0000_0000_0000);
      @(posedge clk); #1;
      set_in(1'b0, 1'b0, 1'b0, 64'd3, 64'h8000_0000_0000_0000);
      repeat (3) @(posedge clk);
      #3;
      check_bit("pre_reset_busy", b0.busy, 1'b1);
      reset = 1'b1;
      #1;
      f = obs(1'b0);
      check("async_reset_flags", w_t'(f), 64'd0);
      check("async_reset_result_ee", b0.result, 64'd0);
      check("async_reset_result_full", b1.result, 64'd0);
      check("async_reset_in_a", b0.alu_in_a, 64'd0);
      check("async_reset_ctrl", w_t'(b0.alu_ctrl), w_t'(NOP));
      @(negedge clk);
      reset = 1'b0;
      last_res0 = 64'd0;
      last_res1 = 64'd0;

      run_op(1'b0, 64'd3, 64'd5, 64'd15, 4, 1'b0);

      waited = 0;
      while ((exp_q0.size() != 0 || exp_q1.size() != 0) && waited < 100) begin
         @(posedge clk);
         waited++;
      end
      check("pending_ee", w_t'(exp_q0.size()), 64'd0);
      check("pending_full", w_t'(exp_q1.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
